text_terminal_writer: RTL and testbench

TEXT_TERMINAL_WRITER -- requirements
Module: text_terminal_writer

---
 rtl/text_terminal_if.sv | 22 ++
 rtl/text_terminal_writer.sv | 197 +++++++++++++++++++
 tb/tb_text_terminal_writer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_terminal_if.sv
// Character input and text-buffer write bus of the terminal writer.
// The writer uses the master modport; the character source and text buffer use slave.
interface text_terminal_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic       write_enable;
  logic [6:0] write_x;
  logic [4:0] write_y;
  logic [6:0] write_data;
  logic       busy;

  modport master (
    input  char_valid, char_data, busy,
    output char_ready, write_enable, write_x, write_y, write_data
  );

  modport slave (
    output char_valid, char_data, busy,
    input  char_ready, write_enable, write_x, write_y, write_data
  );
endinterface

// File: rtl/text_terminal_writer.sv
// Turns a character stream into text-buffer cell writes and tracks the cursor.
// Handles printable codes, LF, CR, BS and FF; every other code is consumed silently.
module text_terminal_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  text_terminal_if.master      bus,
  output logic [6:0]           cursor_x,
  output logic [4:0]           cursor_y
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] SPACE    = 7'h20;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    CLEAR_ROW = 2'd2,
    CLEAR_ALL = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic       ready_r, ready_s;
  logic       we_r, we_s;
  logic [6:0] wx_r, wx_s;
  logic [4:0] wy_r, wy_s;
  logic [6:0] wd_r, wd_s;
  logic [6:0] cx_r, cx_s;
  logic [4:0] cy_r, cy_s;
  logic       bs_r, bs_s;
  logic       accept_s;
  logic       wr_done_s;
  logic [4:0] row_next_s;

  assign bus.char_ready   = ready_r;
  assign bus.write_enable = we_r;
  assign bus.write_x      = wx_r;
  assign bus.write_y      = wy_r;
  assign bus.write_data   = wd_r;
  assign cursor_x         = cx_r;
  assign cursor_y         = cy_r;

  // Next-state and next-output logic; every output is computed here and registered below
  always_comb begin
    state_s    = state_r;
    we_s       = we_r;
    wx_s       = wx_r;
    wy_s       = wy_r;
    wd_s       = wd_r;
    cx_s       = cx_r;
    cy_s       = cy_r;
    bs_s       = bs_r;
    accept_s   = ready_r && bus.char_valid;
    wr_done_s  = we_r && !bus.busy;
    row_next_s = (cy_r == LAST_ROW) ? 5'd0 : cy_r + 5'd1;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if ((bus.char_data >= 8'h20) && (bus.char_data <= 8'h7E)) begin
            state_s = WRITE;
            we_s    = 1'b1;
            wx_s    = cx_r;
            wy_s    = cy_r;
            wd_s    = bus.char_data[6:0];
            bs_s    = 1'b0;
          end else if (bus.char_data == 8'h0A) begin
            cx_s    = 7'd0;
            cy_s    = row_next_s;
            state_s = CLEAR_ROW;
            we_s    = 1'b1;
            wx_s    = 7'd0;
            wy_s    = row_next_s;
            wd_s    = SPACE;
          end else if (bus.char_data == 8'h0D) begin
            cx_s = 7'd0;
          end else if (bus.char_data == 8'h08) begin
            // Backspace at column 0 is a no-op; otherwise blank the previous cell
            if (cx_r != 7'd0) begin
              state_s = WRITE;
              we_s    = 1'b1;
              wx_s    = cx_r - 7'd1;
              wy_s    = cy_r;
              wd_s    = SPACE;
              bs_s    = 1'b1;
            end else begin
              state_s = IDLE;
            end
          end else if (bus.char_data == 8'h0C) begin
            state_s = CLEAR_ALL;
            we_s    = 1'b1;
            wx_s    = 7'd0;
            wy_s    = 5'd0;
            wd_s    = SPACE;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end

      WRITE: begin
        if (wr_done_s) begin
          if (bs_r) begin
            cx_s    = cx_r - 7'd1;
            we_s    = 1'b0;
            state_s = IDLE;
          end else if (cx_r == LAST_COL) begin
            // Line wrap: the new row is blanked before more text is taken
            cx_s    = 7'd0;
            cy_s    = row_next_s;
            state_s = CLEAR_ROW;
            wx_s    = 7'd0;
            wy_s    = row_next_s;
            wd_s    = SPACE;
          end else begin
            cx_s    = cx_r + 7'd1;
            we_s    = 1'b0;
            state_s = IDLE;
          end
        end else begin
          state_s = WRITE;
        end
      end

      CLEAR_ROW: begin
        if (wr_done_s) begin
          if (wx_r == LAST_COL) begin
            we_s    = 1'b0;
            state_s = IDLE;
          end else begin
            wx_s = wx_r + 7'd1;
          end
        end else begin
          state_s = CLEAR_ROW;
        end
      end

      CLEAR_ALL: begin
        if (wr_done_s) begin
          if (wx_r == LAST_COL) begin
            if (wy_r == LAST_ROW) begin
              we_s    = 1'b0;
              cx_s    = 7'd0;
              cy_s    = 5'd0;
              state_s = IDLE;
            end else begin
              wx_s = 7'd0;
              wy_s = wy_r + 5'd1;
            end
          end else begin
            wx_s = wx_r + 7'd1;
          end
        end else begin
          state_s = CLEAR_ALL;
        end
      end

      default: begin
        state_s = IDLE;
        we_s    = 1'b0;
      end
    endcase

    ready_s = (state_s == IDLE);
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
      we_r    <= 1'b0;
      wx_r    <= 7'd0;
      wy_r    <= 5'd0;
      wd_r    <= 7'd0;
      cx_r    <= 7'd0;
      cy_r    <= 5'd0;
      bs_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= ready_s;
      we_r    <= we_s;
      wx_r    <= wx_s;
      wy_r    <= wy_s;
      wd_r    <= wd_s;
      cx_r    <= cx_s;
      cy_r    <= cy_s;
      bs_r    <= bs_s;
    end
  end

endmodule

// File: tb/tb_text_terminal_writer.sv
// Self-checking bench: a cursor/write-list model predicts every accepted write and
// the idle cursor; directed scenarios add literal checks on top of the model.
module tb_text_terminal_writer;
  localparam int COLS = 80;
  localparam int ROWS = 30;

  typedef struct packed {
    logic [6:0] x;
    logic [4:0] y;
    logic [6:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;

  text_terminal_if bus();

  text_terminal_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y)
  );

  always #5 clk = ~clk;

  int  tests = 0;
  int  fails = 0;
  wr_t exp_q[$];
  wr_t log_q[$];
  int  mx = 0;
  int  my = 0;
  int  busy_mode = 0;
  logic prev_stall = 1'b0;
  wr_t  held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input int x, input int y, input int d);
    wr_t w;
    w.x = 7'(x);
    w.y = 5'(y);
    w.d = 7'(d);
    exp_q.push_back(w);
  endfunction

  function automatic void adv_row();
    my = (my == ROWS - 1) ? 0 : my + 1;
    for (int c = 0; c < COLS; c++) push(c, my, 32);
  endfunction

  // Terminal behaviour: list of cell writes a character produces and the final cursor
  function automatic void model_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push(mx, my, int'(c[6:0]));
      mx++;
      if (mx == COLS) begin
        mx = 0;
        adv_row();
      end
    end else if (c == 8'h0A) begin
      mx = 0;
      adv_row();
    end else if (c == 8'h0D) begin
      mx = 0;
    end else if (c == 8'h08) begin
      if (mx > 0) begin
        mx--;
        push(mx, my, 32);
      end
    end else if (c == 8'h0C) begin
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++) push(x, y, 32);
      mx = 0;
      my = 0;
    end
  endfunction

  always @(posedge clk) begin
    #2;
    case (busy_mode)
      0:       bus.busy = 1'b0;
      1:       bus.busy = 1'b1;
      default: bus.busy = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare process: runs on every falling edge while out of reset
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_we", bus.write_enable, 1);
        chk("stall_x", bus.write_x, held.x);
        chk("stall_y", bus.write_y, held.y);
        chk("stall_d", bus.write_data, held.d);
      end
      if (bus.write_enable === 1'b1) begin
        chk("x_in_range", (bus.write_x < COLS) ? 1 : 0, 1);
        chk("y_in_range", (bus.write_y < ROWS) ? 1 : 0, 1);
      end
      if (bus.write_enable === 1'b1 && bus.busy === 1'b0) begin
        wr_t w;
        w.x = bus.write_x;
        w.y = bus.write_y;
        w.d = bus.write_data;
        log_q.push_back(w);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {13'd0, w}, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_x", w.x, e.x);
          chk("wr_y", w.y, e.y);
          chk("wr_d", w.d, e.d);
        end
      end
      prev_stall = (bus.write_enable === 1'b1) && (bus.busy === 1'b1);
      held.x = bus.write_x;
      held.y = bus.write_y;
      held.d = bus.write_data;
      if (bus.char_ready === 1'b1) begin
        chk("idle_cur_x", cursor_x, mx);
        chk("idle_cur_y", cursor_y, my);
        chk("idle_no_pending", exp_q.size(), 0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the character was taken
  task automatic send(input logic [7:0] c);
    int k = 0;
    while (bus.char_ready !== 1'b1 && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 5000) chk("send_timeout", 0, 1);
    bus.char_valid = 1'b1;
    bus.char_data  = c;
    @(posedge clk); #1;
    bus.char_valid = 1'b0;
    model_char(c);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(bus.char_ready === 1'b1 && exp_q.size() == 0) && k < 10000) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 10000) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_cursor(input string name, input int x, input int y);
    chk({name, "_cx"}, cursor_x, x);
    chk({name, "_cy"}, cursor_y, y);
  endtask

  task automatic chk_wr(input string name, input wr_t w, input int x, input int y, input int d);
    chk({name, "_x"}, w.x, x);
    chk({name, "_y"}, w.y, y);
    chk({name, "_d"}, w.d, d);
  endtask

  initial begin
    int base;
    logic [7:0] others [5];
    others[0] = 8'h80; others[1] = 8'h7F; others[2] = 8'h00;
    others[3] = 8'h1B; others[4] = 8'hFF;

    reset = 1'b1;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.char_ready, 0);
    chk("rst_we", bus.write_enable, 0);
    chk("rst_x", bus.write_x, 0);
    chk("rst_y", bus.write_y, 0);
    chk("rst_d", bus.write_data, 0);
    chk_cursor("rst", 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", bus.char_ready, 1);

    // Single printable character
    base = n_log();
    send(8'h41);
    wait_idle();
    chk("A_count", n_log() - base, 1);
    chk_wr("A_wr", log_q[base], 0, 0, 8'h41);
    chk_cursor("A", 1, 0);
    chk("A_ready", bus.char_ready, 1);

    send(8'h0D);
    wait_idle();
    chk_cursor("CR", 0, 0);

    for (int i = 0; i < 29; i++) begin
      send(8'h0A);
      wait_idle();
    end
    chk_cursor("LF29", 0, 29);
    for (int i = 0; i < 79; i++) begin
      send(8'h61 + 8'(i % 26));
      wait_idle();
    end
    chk_cursor("fill", 79, 29);

    // Wrap at the bottom-right cell blanks row 0
    base = n_log();
    send(8'h5A);
    wait_idle();
    chk("Z_count", n_log() - base, 81);
    chk_wr("Z_first", log_q[base], 79, 29, 8'h5A);
    chk_wr("Z_clr0", log_q[base + 1], 0, 0, 8'h20);
    chk_wr("Z_last", log_q[base + 80], 79, 0, 8'h20);
    chk_cursor("Z", 0, 0);

    // Held request under busy
    busy_mode = 1;
    base = n_log();
    send(8'h42);
    repeat (5) begin
      @(posedge clk); #1;
      chk("B_held_we", bus.write_enable, 1);
    end
    chk("B_none_yet", n_log() - base, 0);
    busy_mode = 0;
    wait_idle();
    chk("B_count", n_log() - base, 1);
    chk_wr("B_wr", log_q[base], 0, 0, 8'h42);

    send(8'h0D);
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      send(8'h0A);
      wait_idle();
    end
    base = n_log();
    send(8'h08);
    wait_idle();
    chk("BS0_count", n_log() - base, 0);
    chk_cursor("BS0", 0, 3);
    for (int i = 0; i < 5; i++) begin
      send(8'h68 + 8'(i));
      wait_idle();
    end
    base = n_log();
    send(8'h08);
    wait_idle();
    chk("BS5_count", n_log() - base, 1);
    chk_wr("BS5_wr", log_q[base], 4, 3, 8'h20);
    chk_cursor("BS5", 4, 3);

    // Full-screen clear
    base = n_log();
    send(8'h0C);
    wait_idle();
    chk("FF_count", n_log() - base, 2400);
    chk_wr("FF_first", log_q[base], 0, 0, 8'h20);
    chk_wr("FF_row1", log_q[base + 80], 0, 1, 8'h20);
    chk_wr("FF_last", log_q[base + 2399], 79, 29, 8'h20);
    chk_cursor("FF", 0, 0);

    for (int i = 0; i < 5; i++) begin
      base = n_log();
      send(others[i]);
      wait_idle();
      chk("other_count", n_log() - base, 0);
    end

    // Random busy during text, wrap-free line feed and a clear row
    busy_mode = 2;
    send(8'h78);
    wait_idle();
    send(8'h0A);
    wait_idle();
    send(8'h6F);
    wait_idle();
    send(8'h6B);
    wait_idle();
    busy_mode = 0;
    chk_cursor("rand", 2, 1);

    // Reset in the middle of a full clear
    send(8'h0C);
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    mx = 0;
    my = 0;
    @(posedge clk); #1;
    chk("midrst_we", bus.write_enable, 0);
    chk_cursor("midrst", 0, 0);
    reset = 1'b0;
    base = n_log();
    repeat (50) @(posedge clk);
    #1;
    chk("midrst_no_writes", n_log() - base, 0);
    chk("midrst_ready", bus.char_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic int n_log();
    return log_q.size();
  endfunction

endmodule
